// File: rtl/instr_mem_responder.sv
// rtl/instr_mem_responder.sv - fixed-latency in-order instruction-memory slave for the MR1 fetch port
module instr_mem_responder #(
  parameter int          ADDR_WORDS_LOG2 = 10,
  parameter int          LATENCY         = 2,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] ILLEGAL_WORD    = 32'h00000000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       instr_req_valid,
  output logic                       instr_req_ready,
  input  logic [31:0]                instr_req_addr,
  output logic                       instr_rsp_valid,
  output logic [31:0]                instr_rsp_data,
  input  logic                       stall,
  input  logic                       load_valid,
  input  logic [ADDR_WORDS_LOG2-1:0] load_addr,
  input  logic [31:0]                load_data,
  output logic [31:0]                rsp_count
);

  localparam int            DEPTH  = 1 << ADDR_WORDS_LOG2;
  localparam int            CW     = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_OS = CW'(MAX_OUTSTANDING);

  logic [31:0]                ram [DEPTH];
  logic [LATENCY-1:0]         pipe_valid;
  logic [31:0]                pipe_data [LATENCY];
  logic [CW-1:0]              outstanding;
  logic [CW-1:0]              outstanding_next;
  logic                       accept;
  logic                       out_of_range;
  logic [ADDR_WORDS_LOG2-1:0] rd_idx;
  logic [31:0]                rd_word;
  logic                       unused_addr_lsbs;

  assign accept           = instr_req_valid && instr_req_ready;
  assign rd_idx           = instr_req_addr[ADDR_WORDS_LOG2+1:2];
  assign out_of_range     = (instr_req_addr >> (ADDR_WORDS_LOG2 + 2)) != 32'd0;
  assign rd_word          = out_of_range ? ILLEGAL_WORD : ram[rd_idx];
  assign unused_addr_lsbs = ^instr_req_addr[1:0];

  // No reset on the array: preloaded contents must survive a mid-run reset.
  always_ff @(posedge clk) begin
    if (load_valid) begin
      ram[load_addr] <= load_data;
    end
  end

  // Stage 0 samples the array in the accept cycle, so a same-cycle preload write returns the old word.
  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_valid <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        pipe_data[i] <= '0;
      end
    end else begin
      pipe_valid[0] <= accept;
      pipe_data[0]  <= accept ? rd_word : '0;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_data[i]  <= pipe_data[i-1];
      end
    end
  end

  assign instr_rsp_valid = pipe_valid[LATENCY-1];
  assign instr_rsp_data  = pipe_valid[LATENCY-1] ? pipe_data[LATENCY-1] : '0;

  always_comb begin
    outstanding_next = outstanding + CW'(accept) - CW'(instr_rsp_valid);
  end

  // Ready looks one cycle ahead so a full pipeline never sees an accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      outstanding     <= '0;
      instr_req_ready <= 1'b0;
      rsp_count       <= '0;
    end else begin
      outstanding     <= outstanding_next;
      instr_req_ready <= !stall && (outstanding_next < MAX_OS);
      if (instr_rsp_valid) begin
        rsp_count <= rsp_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_instr_mem_responder.sv
// tb/tb_instr_mem_responder.sv - directed bench for instr_mem_responder (LATENCY=2/MAX=2 and LATENCY=3/MAX=1)
module tb_instr_mem_responder;

  logic        clk;
  logic        reset;
  logic        instr_req_valid;
  logic [31:0] instr_req_addr;
  logic        stall;
  logic        load_valid;
  logic [9:0]  load_addr;
  logic [31:0] load_data;

  logic        ready1, rsp_valid1, ready2, rsp_valid2;
  logic [31:0] rsp_data1, rsp_count1, rsp_data2, rsp_count2;

  instr_mem_responder dut (
    .clk(clk), .reset(reset),
    .instr_req_valid(instr_req_valid), .instr_req_ready(ready1), .instr_req_addr(instr_req_addr),
    .instr_rsp_valid(rsp_valid1), .instr_rsp_data(rsp_data1),
    .stall(stall), .load_valid(load_valid), .load_addr(load_addr), .load_data(load_data),
    .rsp_count(rsp_count1)
  );

  instr_mem_responder #(.LATENCY(3), .MAX_OUTSTANDING(1)) dut2 (
    .clk(clk), .reset(reset),
    .instr_req_valid(instr_req_valid), .instr_req_ready(ready2), .instr_req_addr(instr_req_addr),
    .instr_rsp_valid(rsp_valid2), .instr_rsp_data(rsp_data2),
    .stall(stall), .load_valid(load_valid), .load_addr(load_addr), .load_data(load_data),
    .rsp_count(rsp_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;

  exp_t        q1[$];
  exp_t        q2[$];
  logic [31:0] shadow [1024];
  logic [31:0] cnt1, cnt2;
  int          total, bad, cyc, last2;
  bit          acc1, acc2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    if (a[31:12] != 20'd0) return 32'h00000000;
    return shadow[a[11:2]];
  endfunction

  task automatic tick();
    exp_t e;
    logic rst_was;
    acc1 = (instr_req_valid === 1'b1) && (ready1 === 1'b1) && !reset;
    acc2 = (instr_req_valid === 1'b1) && (ready2 === 1'b1) && !reset;
    if (acc1) begin
      e.due = cyc + 2; e.data = exp_word(instr_req_addr); q1.push_back(e);
    end
    if (acc2) begin
      if (last2 >= 0) chk("dut2_accept_spacing", 32'((cyc - last2) >= 3), 32'd1);
      last2 = cyc;
      e.due = cyc + 3; e.data = exp_word(instr_req_addr); q2.push_back(e);
    end
    if (load_valid) shadow[load_addr] = load_data;
    rst_was = reset;
    @(posedge clk);
    #1;
    cyc++;
    if (rst_was) begin
      q1.delete(); q2.delete(); cnt1 = '0; cnt2 = '0; last2 = -1;
    end
    chk("rsp1_count", rsp_count1, cnt1);
    if (q1.size() > 0 && q1[0].due == cyc) begin
      chk("rsp1_valid", 32'(rsp_valid1), 32'd1);
      chk("rsp1_data", rsp_data1, q1[0].data);
      void'(q1.pop_front());
      cnt1++;
    end else begin
      chk("rsp1_idle_valid", 32'(rsp_valid1), 32'd0);
      chk("rsp1_idle_data", rsp_data1, 32'h0);
    end
    chk("rsp2_count", rsp_count2, cnt2);
    if (q2.size() > 0 && q2[0].due == cyc) begin
      chk("rsp2_valid", 32'(rsp_valid2), 32'd1);
      chk("rsp2_data", rsp_data2, q2[0].data);
      void'(q2.pop_front());
      cnt2++;
    end else begin
      chk("rsp2_idle_valid", 32'(rsp_valid2), 32'd0);
      chk("rsp2_idle_data", rsp_data2, 32'h0);
    end
    chk("os1_bound", 32'(q1.size() <= 2), 32'd1);
    chk("os2_bound", 32'(q2.size() <= 1), 32'd1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic issue(input logic [31:0] a, input string tag, output int acc_cyc);
    bit got;
    got = 1'b0;
    acc_cyc = -1;
    instr_req_valid = 1'b1;
    instr_req_addr  = a;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (acc1) begin got = 1'b1; acc_cyc = cyc - 1; end
    end
    instr_req_valid = 1'b0;
    chk({tag, "_accept"}, 32'(got), 32'd1);
  endtask

  task automatic wait_rsp(input int acc_cyc, input logic [31:0] expv, input string tag);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (rsp_valid1 === 1'b1) got = 1'b1;
      else tick();
    end
    chk({tag, "_rsp"}, 32'(got), 32'd1);
    chk({tag, "_latency"}, 32'(cyc - acc_cyc), 32'd2);
    chk({tag, "_data"}, rsp_data1, expv);
  endtask

  task automatic fetch(input logic [31:0] a, input logic [31:0] expv, input string tag);
    int ac;
    issue(a, tag, ac);
    wait_rsp(ac, expv, tag);
  endtask

  initial begin
    int n, n2, ac;
    total = 0; bad = 0; cyc = 0; last2 = -1; cnt1 = '0; cnt2 = '0;
    reset = 1'b1; instr_req_valid = 1'b0; instr_req_addr = '0; stall = 1'b0;
    load_valid = 1'b0; load_addr = '0; load_data = '0;

    load_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      load_addr = 10'(i); load_data = 32'h00208133; tick();
    end
    load_addr = 10'd5;    load_data = 32'h11111111; tick();
    load_addr = 10'd1023; load_data = 32'hA5A50FFC; tick();
    load_valid = 1'b0;
    chk("rst_ready1", 32'(ready1), 32'd0);
    chk("rst_ready2", 32'(ready2), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid1), 32'd0);
    chk("rst_rsp_data", rsp_data1, 32'h0);
    chk("rst_rsp_count", rsp_count1, 32'h0);
    reset = 1'b0;
    tick();
    chk("rst_release_ready", 32'(ready1), 32'd1);

    instr_req_valid = 1'b1; instr_req_addr = 32'h0; n = 0;
    for (int i = 0; i < 30 && n < 4; i++) begin
      tick();
      if (acc1) begin n++; instr_req_addr = instr_req_addr + 32'd4; end
    end
    instr_req_valid = 1'b0;
    chk("t1_accepts", 32'(n), 32'd4);
    idle(5);
    chk("t1_rsp_count", rsp_count1, 32'd4);

    idle(5);
    instr_req_valid = 1'b1; instr_req_addr = 32'h4; n2 = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (acc2) n2++;
    end
    instr_req_valid = 1'b0;
    chk("t2_accepts_in_12", 32'(n2), 32'd3);
    idle(5);

    fetch(32'h0001_0000, 32'h00000000, "t3_oor");
    fetch(32'h0000_0FFC, 32'hA5A50FFC, "t3_last");

    idle(4);
    chk("t4_ready", 32'(ready1), 32'd1);
    load_valid = 1'b1; load_addr = 10'd5; load_data = 32'hDEADBEEF;
    instr_req_valid = 1'b1; instr_req_addr = 32'h14;
    tick();
    ac = cyc - 1;
    load_valid = 1'b0; instr_req_valid = 1'b0;
    chk("t4_same_cycle_accept", 32'(acc1), 32'd1);
    wait_rsp(ac, 32'h11111111, "t4_old");
    fetch(32'h14, 32'hDEADBEEF, "t4_new");

    idle(4);
    instr_req_valid = 1'b1; instr_req_addr = 32'h0;
    tick();
    chk("t5_acc_a", 32'(acc1), 32'd1);
    tick();
    chk("t5_acc_b", 32'(acc1), 32'd1);
    instr_req_valid = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_ready_after_reset", 32'(ready1), 32'd0);
    chk("t5_rsp_dropped", 32'(rsp_valid1), 32'd0);
    chk("t5_count_cleared", rsp_count1, 32'h0);
    tick();
    chk("t5_ready_back", 32'(ready1), 32'd1);
    chk("t5_rsp_still_dropped", 32'(rsp_valid1), 32'd0);
    fetch(32'h8, 32'h00208133, "t5_ram_kept");

    idle(4);
    instr_req_valid = 1'b1; instr_req_addr = 32'h0;
    tick();
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t6_ready1_stalled", 32'(ready1), 32'd0);
      chk("t6_ready2_stalled", 32'(ready2), 32'd0);
    end
    stall = 1'b0;
    tick();
    chk("t6_ready1_resume", 32'(ready1), 32'd1);
    chk("t6_ready2_resume", 32'(ready2), 32'd1);
    tick();
    chk("t6_accept_resume", 32'(acc1), 32'd1);
    instr_req_valid = 1'b0;
    idle(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
